// File: rtl/exec_pkg.sv
// ---------------------------------------------------------------------------
// exec_pkg
// Shared definitions for the Y86 execute-stage controller:
//   - icode constants (HALT .. POPQ)
//   - ALU function codes driven on alu_fun
//   - jXX / cmovXX condition codes (ifun 0..6)
//   - bit positions of ZF/SF/OF inside the 3-bit condition-code vector
//   - controller FSM state enum
//   - the +8 / -8 stack-pointer adjustment constants
//   - instr_err(): illegal icode/ifun classification
// ---------------------------------------------------------------------------
package exec_pkg;

    // Instruction codes
    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;   // also cmovXX
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    // ALU function codes
    localparam logic [3:0] ALU_ADD = 4'h0;
    localparam logic [3:0] ALU_SUB = 4'h1;
    localparam logic [3:0] ALU_AND = 4'h2;
    localparam logic [3:0] ALU_XOR = 4'h3;

    // Branch / conditional-move condition codes
    localparam logic [3:0] C_YES = 4'h0;
    localparam logic [3:0] C_LE  = 4'h1;
    localparam logic [3:0] C_L   = 4'h2;
    localparam logic [3:0] C_E   = 4'h3;
    localparam logic [3:0] C_NE  = 4'h4;
    localparam logic [3:0] C_GE  = 4'h5;
    localparam logic [3:0] C_G   = 4'h6;

    // Bit positions inside the {ZF,SF,OF} vector
    localparam int CC_ZF = 2;
    localparam int CC_SF = 1;
    localparam int CC_OF = 0;

    // Controller FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_DONE = 2'b10
    } exec_state_e;

    // Stack pointer adjustments (two's complement -8 is added, never subtracted)
    localparam logic [63:0] STACK_INC = 64'h0000_0000_0000_0008;
    localparam logic [63:0] STACK_DEC = 64'hFFFF_FFFF_FFFF_FFF8;

    // Illegal instruction detection. cond_err is the "ifun outside 0..6"
    // verdict of the condition evaluator, only relevant for cmovXX/jXX.
    function automatic logic instr_err(input logic [3:0] icode,
                                       input logic [3:0] ifun,
                                       input logic       cond_err);
        logic err;
        if (icode > I_POPQ) begin
            err = 1'b1;
        end else if (icode == I_OPQ) begin
            err = (ifun > ALU_XOR);
        end else if ((icode == I_RRMOVQ) || (icode == I_JXX)) begin
            err = cond_err;
        end else begin
            err = 1'b0;
        end
        return err;
    endfunction

endpackage

// File: rtl/exec_cond_eval.sv
// ---------------------------------------------------------------------------
// exec_cond_eval
// Purely combinational jXX/cmovXX condition evaluator.
//   ifun     in  4  condition code (0 always .. 6 greater)
//   cc       in  3  condition flags {ZF,SF,OF}
//   cnd      out 1  condition outcome (0 when ifun is not a condition)
//   cond_err out 1  ifun does not name a condition
// Kept separate so later cmov forwarding logic can reuse it.
// ---------------------------------------------------------------------------
module exec_cond_eval (
    input  logic [3:0] ifun,
    input  logic [2:0] cc,
    output logic       cnd,
    output logic       cond_err
);
    import exec_pkg::*;

    logic zf_s;
    logic sf_s;
    logic of_s;

    assign zf_s = cc[CC_ZF];
    assign sf_s = cc[CC_SF];
    assign of_s = cc[CC_OF];

    // Decode the condition from the flags
    always_comb begin
        cnd      = 1'b0;
        cond_err = 1'b0;
        case (ifun)
            C_YES:   cnd = 1'b1;
            C_LE:    cnd = (sf_s ^ of_s) | zf_s;
            C_L:     cnd = sf_s ^ of_s;
            C_E:     cnd = zf_s;
            C_NE:    cnd = ~zf_s;
            C_GE:    cnd = ~(sf_s ^ of_s);
            C_G:     cnd = ~(sf_s ^ of_s) & ~zf_s;
            default: begin
                cnd      = 1'b0;
                cond_err = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/exec_stage_ctrl.sv
// ---------------------------------------------------------------------------
// exec_stage_ctrl
// Y86 execute-stage sequencing controller: IDLE -> EXEC -> DONE.
//   clk, rst                    clock, synchronous active-high reset
//   in_valid/in_ready           decode handshake (in_ready only in IDLE)
//   in_icode/in_ifun            instruction fields
//   in_valA/in_valB/in_valC     operands
//   flush                       drop the in-flight instruction (EXEC/DONE)
//   alu_a/alu_b/alu_fun         operands/function for the external ALU
//   alu_valE/alu_cf             ALU result and {ZF,SF,OF}, combinational
//   out_valid/out_ready         memory-stage handshake
//   out_icode/out_valE/out_cnd/out_err  presented result
//   cc                          committed condition codes {ZF,SF,OF}
// ALU operands are muxed from the incoming fields at the accept edge so the
// ALU sees registered values during EXEC; outside EXEC they are 0/0/add.
// ---------------------------------------------------------------------------
module exec_stage_ctrl #(
    parameter int         W        = 64,
    parameter logic [2:0] CC_RESET = 3'b100
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [3:0]   in_icode,
    input  logic [3:0]   in_ifun,
    input  logic [W-1:0] in_valA,
    input  logic [W-1:0] in_valB,
    input  logic [W-1:0] in_valC,
    input  logic         flush,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    output logic [3:0]   alu_fun,
    input  logic [W-1:0] alu_valE,
    input  logic [2:0]   alu_cf,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [3:0]   out_icode,
    output logic [W-1:0] out_valE,
    output logic         out_cnd,
    output logic         out_err,
    output logic [2:0]   cc
);
    import exec_pkg::*;

    exec_state_e  state_q,     state_d;
    logic         in_ready_q,  in_ready_d;
    logic [3:0]   icode_q,     icode_d;
    logic [3:0]   ifun_q,      ifun_d;
    logic [W-1:0] alu_a_q,     alu_a_d;
    logic [W-1:0] alu_b_q,     alu_b_d;
    logic [3:0]   alu_fun_q,   alu_fun_d;
    logic [2:0]   pend_cf_q,   pend_cf_d;
    logic         out_valid_q, out_valid_d;
    logic [3:0]   out_icode_q, out_icode_d;
    logic [W-1:0] out_vale_q,  out_vale_d;
    logic         out_cnd_q,   out_cnd_d;
    logic         out_err_q,   out_err_d;
    logic [2:0]   cc_q,        cc_d;

    logic [W-1:0] op_a_s;
    logic [W-1:0] op_b_s;
    logic [3:0]   op_fun_s;
    logic         cnd_s;
    logic         cond_err_s;
    logic         err_s;
    logic         cnd_eff_s;

    // Condition is judged on committed cc, never on pending flags
    exec_cond_eval u_cond (
        .ifun     (ifun_q),
        .cc       (cc_q),
        .cnd      (cnd_s),
        .cond_err (cond_err_s)
    );

    assign err_s = instr_err(icode_q, ifun_q, cond_err_s);

    // Condition outcome only exists for legal cmovXX/jXX
    always_comb begin
        if (err_s) begin
            cnd_eff_s = 1'b0;
        end else if ((icode_q == I_RRMOVQ) || (icode_q == I_JXX)) begin
            cnd_eff_s = cnd_s;
        end else begin
            cnd_eff_s = 1'b0;
        end
    end

    // ALU operand/function selection from the instruction being offered
    always_comb begin
        op_a_s   = {W{1'b0}};
        op_b_s   = {W{1'b0}};
        op_fun_s = ALU_ADD;
        case (in_icode)
            I_RRMOVQ: begin
                op_a_s = in_valA;
            end
            I_IRMOVQ: begin
                op_a_s = in_valC;
            end
            I_RMMOVQ, I_MRMOVQ: begin
                op_a_s = in_valC;
                op_b_s = in_valB;
            end
            I_OPQ: begin
                op_a_s   = in_valA;
                op_b_s   = in_valB;
                op_fun_s = {2'b00, in_ifun[1:0]};
            end
            I_CALL, I_PUSHQ: begin
                op_a_s = W'(STACK_DEC);
                op_b_s = in_valB;
            end
            I_RET, I_POPQ: begin
                op_a_s = W'(STACK_INC);
                op_b_s = in_valB;
            end
            default: begin
                op_a_s   = {W{1'b0}};
                op_b_s   = {W{1'b0}};
                op_fun_s = ALU_ADD;
            end
        endcase
    end

    // Next-state and next-output computation for the sequencing FSM
    always_comb begin
        state_d     = state_q;
        icode_d     = icode_q;
        ifun_d      = ifun_q;
        alu_a_d     = {W{1'b0}};
        alu_b_d     = {W{1'b0}};
        alu_fun_d   = ALU_ADD;
        pend_cf_d   = pend_cf_q;
        out_valid_d = out_valid_q;
        out_icode_d = out_icode_q;
        out_vale_d  = out_vale_q;
        out_cnd_d   = out_cnd_q;
        out_err_d   = out_err_q;
        cc_d        = cc_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d   = ST_EXEC;
                    icode_d   = in_icode;
                    ifun_d    = in_ifun;
                    alu_a_d   = op_a_s;
                    alu_b_d   = op_b_s;
                    alu_fun_d = op_fun_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EXEC: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d     = ST_DONE;
                    pend_cf_d   = alu_cf;
                    out_valid_d = 1'b1;
                    out_icode_d = icode_q;
                    out_vale_d  = err_s ? {W{1'b0}} : alu_valE;
                    out_cnd_d   = cnd_eff_s;
                    out_err_d   = err_s;
                end
            end
            ST_DONE: begin
                // flush wins over out_ready: nothing is committed
                if (flush) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                end else if (out_ready) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                    if ((icode_q == I_OPQ) && !out_err_q) begin
                        cc_d = pend_cf_q;
                    end else begin
                        cc_d = cc_q;
                    end
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
            end
        endcase
        in_ready_d = (state_d == ST_IDLE);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            in_ready_q  <= 1'b1;
            icode_q     <= 4'h0;
            ifun_q      <= 4'h0;
            alu_a_q     <= {W{1'b0}};
            alu_b_q     <= {W{1'b0}};
            alu_fun_q   <= ALU_ADD;
            pend_cf_q   <= 3'b000;
            out_valid_q <= 1'b0;
            out_icode_q <= 4'h0;
            out_vale_q  <= {W{1'b0}};
            out_cnd_q   <= 1'b0;
            out_err_q   <= 1'b0;
            cc_q        <= CC_RESET;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            icode_q     <= icode_d;
            ifun_q      <= ifun_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_fun_q   <= alu_fun_d;
            pend_cf_q   <= pend_cf_d;
            out_valid_q <= out_valid_d;
            out_icode_q <= out_icode_d;
            out_vale_q  <= out_vale_d;
            out_cnd_q   <= out_cnd_d;
            out_err_q   <= out_err_d;
            cc_q        <= cc_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_fun   = alu_fun_q;
    assign out_valid = out_valid_q;
    assign out_icode = out_icode_q;
    assign out_valE  = out_vale_q;
    assign out_cnd   = out_cnd_q;
    assign out_err   = out_err_q;
    assign cc        = cc_q;

endmodule
